mem_writeback_queue: RTL

//  Write-back stage of the SIMD pipeline: gathers PE vector results or serially shifted scalar results

---
 rtl/mem_writeback_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_writeback_queue.sv
// rtl/mem_writeback_queue.sv - SIMD write-back row gatherer with a masked, addressed store queue to DMEM
module mem_writeback_queue #(
    parameter int PE_ELEMENTS = 4,
    parameter int DMEM_DEPTH  = 1024,
    parameter int DATA_LEN    = 32,
    parameter int QUEUE_DEPTH = 4,
    localparam int AW         = $clog2(DMEM_DEPTH / PE_ELEMENTS)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [PE_ELEMENTS*DATA_LEN-1:0] vec_in,
    input  logic                            vec_valid,
    input  logic [DATA_LEN-1:0]             scl_in,
    input  logic                            scl_valid,
    input  logic                            store_req,
    input  logic                            store_auto,
    input  logic [AW-1:0]                   store_addr,
    output logic                            store_ready,
    output logic                            mem_en,
    input  logic                            mem_ready,
    output logic [AW-1:0]                   mem_addr,
    output logic [PE_ELEMENTS*DATA_LEN-1:0] mem_din,
    output logic [PE_ELEMENTS-1:0]          mem_lane_we,
    output logic                            busy,
    output logic                            store_drop,
    output logic                            in_collision
);

    localparam int RW = PE_ELEMENTS * DATA_LEN;
    localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [QW:0] FULL = (QW+1)'(QUEUE_DEPTH);

    logic [RW-1:0]          row_q, row_d;
    logic [PE_ELEMENTS-1:0] mask_q, mask_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [QW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [QW:0]            count_q, count_d;
    logic                   drop_q, drop_d;
    logic                   coll_q, coll_d;

    logic [AW-1:0]          qa_q [QUEUE_DEPTH];
    logic [AW-1:0]          qa_d [QUEUE_DEPTH];
    logic [RW-1:0]          qd_q [QUEUE_DEPTH];
    logic [RW-1:0]          qd_d [QUEUE_DEPTH];
    logic [PE_ELEMENTS-1:0] qm_q [QUEUE_DEPTH];
    logic [PE_ELEMENTS-1:0] qm_d [QUEUE_DEPTH];

    logic                   push, pop;
    logic [AW-1:0]          push_addr;
    logic [RW-1:0]          row_base;
    logic [PE_ELEMENTS-1:0] mask_base;

    assign store_ready  = (count_q != FULL);
    assign mem_en       = (count_q != '0);
    assign busy         = mem_en;
    assign store_drop   = drop_q;
    assign in_collision = coll_q;
    assign mem_addr     = mem_en ? qa_q[rd_q] : '0;
    assign mem_din      = mem_en ? qd_q[rd_q] : '0;
    assign mem_lane_we  = mem_en ? qm_q[rd_q] : '0;

    always_comb begin
        push      = store_req && store_ready;
        pop       = mem_en && mem_ready;
        push_addr = store_auto ? ptr_q : store_addr;

        // A committed row is cleared on the same edge, so updates land on an empty row
        row_base  = push ? '0 : row_q;
        mask_base = push ? '0 : mask_q;

        row_d  = row_base;
        mask_d = mask_base;
        if (vec_valid) begin
            row_d  = vec_in;
            mask_d = '1;
        end else if (scl_valid) begin
            row_d  = {scl_in, row_base[RW-1:DATA_LEN]};
            mask_d = {1'b1, mask_base[PE_ELEMENTS-1:1]};
        end

        ptr_d   = push ? push_addr + AW'(1) : ptr_q;
        drop_d  = store_req && !store_ready;
        coll_d  = vec_valid && scl_valid;

        qa_d = qa_q;
        qd_d = qd_q;
        qm_d = qm_q;
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            qa_d[wr_q] = push_addr;
            qd_d[wr_q] = row_q;
            qm_d[wr_q] = mask_q;
            wr_d       = wr_q + QW'(1);
        end
        if (pop) begin
            rd_d = rd_q + QW'(1);
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (QW+1)'(1);
            2'b01:   count_d = count_q - (QW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_q   <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            coll_q  <= coll_d;
        end
    end

    // Entry storage needs no reset: outputs are gated by the occupancy count
    always_ff @(posedge clk) begin
        qa_q <= qa_d;
        qd_q <= qd_d;
        qm_q <= qm_d;
    end

endmodule
